// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the clock-enable generator.
package clk_gen_pkg;
  localparam int DIV_W_DEF       = 27;
  localparam int MIN_DIV         = 2;
  localparam int DEFAULT_DIV_DEF = 100_000_000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Channel-select width, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_enable_gen_if.sv
// Control and output bundle of clk_enable_gen.
interface clk_enable_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = clk_gen_pkg::DIV_W_DEF
);
  localparam int SEL_W = clk_gen_pkg::sel_w(NUM_CH);

  logic [NUM_CH-1:0] ch_en;
  logic              sync_clr;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [DIV_W-1:0]  div_val;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq_out;
  logic              div_err;

  modport master (
    output ch_en, sync_clr, div_wr, div_sel, div_val,
    input  tick, sq_out, div_err
  );
  modport slave (
    input  ch_en, sync_clr, div_wr, div_sel, div_val,
    output tick, sq_out, div_err
  );
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow ratio, tick strobe and square wave.
module clk_div_channel
  import clk_gen_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  output logic             tick,
  output logic             sq_out
);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt, div_act, div_pend, div_nxt, half;
  logic             pend, wrap, apply, restart, set_hi;

  always_comb begin
    half    = div_act >> 1;
    wrap    = en && (cnt == div_act - ONE);
    set_hi  = (cnt == half - ONE);
    restart = sync_clr || !en || wrap;
    // Ratio changes only land where cnt restarts, so no runt periods.
    apply   = restart;
    div_nxt = wr ? wr_val : (pend ? div_pend : div_act);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      div_act  <= DIV_RST;
      div_pend <= DIV_RST;
      pend     <= 1'b0;
      tick     <= 1'b0;
      sq_out   <= 1'b0;
    end else begin
      if (wr) div_pend <= wr_val;
      if (apply) begin
        div_act <= div_nxt;
        pend    <= 1'b0;
      end else if (wr) begin
        pend    <= 1'b1;
      end
      tick <= wrap && !sync_clr;
      cnt  <= restart ? '0 : cnt + ONE;
      if (restart)     sq_out <= 1'b0;
      else if (set_hi) sq_out <= 1'b1;
    end
  end
endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: write decode, error flag, channel array.
module clk_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  clk_enable_gen_if.slave  bus
);
  localparam int SEL_W = sel_w(NUM_CH);

  logic              wr_ok;
  logic [NUM_CH-1:0] ch_wr, tick_w, sq_w;

  always_comb begin
    wr_ok = bus.div_wr && (int'(bus.div_sel) < NUM_CH) &&
            (bus.div_val >= DIV_W'(MIN_DIV));
    for (int i = 0; i < NUM_CH; i++)
      ch_wr[i] = wr_ok && (bus.div_sel == SEL_W'(i));
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) bus.div_err <= 1'b0;
    else       bus.div_err <= bus.div_wr && !wr_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .en         (bus.ch_en[i]),
      .sync_clr   (bus.sync_clr),
      .wr         (ch_wr[i]),
      .wr_val     (bus.div_val),
      .tick       (tick_w[i]),
      .sq_out     (sq_w[i])
    );
  end

  assign bus.tick   = tick_w;
  assign bus.sq_out = sq_w;
endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench: stimulus queues expected tick/div_err cycles, a monitor consumes them.
module tb_clk_enable_gen;
  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int DEFDIV = 10;

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b1;
  always #5 clk_100MHz = ~clk_100MHz;

  clk_enable_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clk_enable_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFDIV)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  int cyc = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int exp_tick [NUM_CH][$];
  int exp_err [$];

  // Number of rising edges seen with reset low.
  always @(posedge clk_100MHz) if (!reset) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic push_ticks(input int ch, input int first, input int step, input int last);
    for (int c = first; c <= last; c += step) exp_tick[ch].push_back(c);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk_100MHz);
  endtask

  task automatic wr(input int sel, input int val);
    bus.div_wr  = 1'b1;
    bus.div_sel = 2'(sel);
    bus.div_val = 8'(val);
  endtask

  always @(negedge clk_100MHz) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      while (exp_tick[ch].size() > 0 && exp_tick[ch][0] < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL tick%0d missing: expected at cyc %0d, none by cyc %0d", ch, exp_tick[ch][0], cyc);
        void'(exp_tick[ch].pop_front());
      end
      if (bus.tick[ch] !== 1'b0) begin
        n_tests++;
        if (bus.tick[ch] === 1'b1 && exp_tick[ch].size() > 0 && exp_tick[ch][0] == cyc)
          void'(exp_tick[ch].pop_front());
        else begin
          n_fail++;
          $display("FAIL tick%0d unexpected: got %b at cyc %0d, next expected %0d", ch, bus.tick[ch], cyc,
                   (exp_tick[ch].size() > 0) ? exp_tick[ch][0] : -1);
        end
      end
    end
    while (exp_err.size() > 0 && exp_err[0] < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL div_err missing: expected at cyc %0d, none by cyc %0d", exp_err[0], cyc);
      void'(exp_err.pop_front());
    end
    if (bus.div_err !== 1'b0) begin
      n_tests++;
      if (bus.div_err === 1'b1 && exp_err.size() > 0 && exp_err[0] == cyc)
        void'(exp_err.pop_front());
      else begin
        n_fail++;
        $display("FAIL div_err unexpected: got %b at cyc %0d", bus.div_err, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ch_en = 3'b011; bus.sync_clr = 1'b0; bus.div_wr = 1'b0;
    bus.div_sel = '0;   bus.div_val = '0;
    #2;
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_sq", 32'(bus.sq_out), 0);
    chk("rst_err", 32'(bus.div_err), 0);
    push_ticks(0, 10, 10, 50);
    push_ticks(1, 10, 10, 30);
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;

    // default ratio 10: low 5, high 5
    for (int c = 1; c <= 10; c++) begin
      go_to(c);
      chk("sq0_div10", 32'(bus.sq_out[0]), 32'((c >= 5 && c <= 9) ? 1 : 0));
    end

    // ratio 4 on ch1 mid-period, applied at its next wrap (cycle 30)
    go_to(23); wr(1, 4); push_ticks(1, 34, 4, 94);
    go_to(24); bus.div_wr = 1'b0;
    for (int c = 30; c <= 34; c++) begin
      go_to(c);
      chk("sq1_div4", 32'(bus.sq_out[1]), 32'((c == 32 || c == 33) ? 1 : 0));
    end

    // rejected writes: ratio below 2, channel out of range
    go_to(41); wr(0, 1); exp_err.push_back(42);
    go_to(42); bus.div_wr = 1'b0;
    go_to(43); wr(3, 5); exp_err.push_back(44);
    go_to(44); bus.div_wr = 1'b0;

    // disable ch0 at cnt0==6, re-enable later
    go_to(56); chk("sq0_pre_dis", 32'(bus.sq_out[0]), 1); bus.ch_en = 3'b010;
    go_to(57); chk("sq0_dis", 32'(bus.sq_out[0]), 0);
    go_to(60); chk("sq0_dis_hold", 32'(bus.sq_out[0]), 0);
    bus.ch_en = 3'b011; push_ticks(0, 70, 10, 80);

    // ratio 3 on ch0: low 1, high 2 after the wrap at 80
    go_to(73); wr(0, 3); push_ticks(0, 83, 3, 104);
    go_to(74); bus.div_wr = 1'b0;
    for (int c = 80; c <= 83; c++) begin
      go_to(c);
      chk("sq0_div3", 32'(bus.sq_out[0]), 32'((c == 81 || c == 82) ? 1 : 0));
    end

    go_to(90); wr(1, 10); push_ticks(1, 104, 10, 104);
    go_to(91); bus.div_wr = 1'b0;

    // pending ratio 6 on ch0, sync_clr lands on ch0's wrap and suppresses its tick
    go_to(105); wr(0, 6);
    go_to(106); bus.div_wr = 1'b0; bus.sync_clr = 1'b1;
    push_ticks(0, 113, 6, 149); push_ticks(1, 117, 10, 137);
    go_to(107); bus.sync_clr = 1'b0;
    chk("sq_after_clr", 32'(bus.sq_out), 0);
    go_to(109); chk("sq0_div6_lo", 32'(bus.sq_out[0]), 0);
    go_to(110); chk("sq0_div6_hi", 32'(bus.sq_out[0]), 1);

    go_to(137); wr(1, 4); push_ticks(1, 147, 4, 151);
    go_to(138); bus.div_wr = 1'b0;
    go_to(153); chk("sq_pre_rst", 32'(bus.sq_out[1:0]), 3);

    // async reset right after both channels tick at cycle 155
    go_to(154);
    @(posedge clk_100MHz); #1;
    chk("tick_pre_rst", 32'(bus.tick[1:0]), 3);
    #1 reset = 1'b1;
    #1;
    chk("async_tick", 32'(bus.tick), 0);
    chk("async_sq", 32'(bus.sq_out), 0);
    chk("async_err", 32'(bus.div_err), 0);
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    push_ticks(0, 165, 10, 175); push_ticks(1, 165, 10, 175);
    go_to(159); chk("sq0_rst_lo", 32'(bus.sq_out[0]), 0);
    go_to(160); chk("sq0_rst_hi", 32'(bus.sq_out[0]), 1);

    go_to(178); bus.ch_en = '0;
    go_to(181);
    for (int ch = 0; ch < NUM_CH; ch++) chk("tick_q_left", 32'(exp_tick[ch].size()), 0);
    chk("err_q_left", 32'(exp_err.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
